// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//
// Purpose:
//    Load unit that issues one data-memory read per accepted load and returns
//    the requested word, halfword or byte, sign- or zero-extended to 32 bits.
//    FSM: IDLE -> WAIT (read outstanding) -> RESP (one-cycle writeback).
//
// Ports:
//    clk        in   1   clock, all state updates on the rising edge
//    reset      in   1   synchronous active-high reset
//    req_valid  in   1   load request present this cycle
//    load_op    in   3   0=LW 1=LH 2=LHU 3=LB 4=LBU, 5-7 reserved (ignored)
//    addr       in  32   byte address of the load
//    flush      in   1   abort any outstanding request
//    busy       out  1   request accepted and not yet completed (stall)
//    mem_rd_en  out  1   one-cycle read strobe, same cycle as acceptance
//    mem_addr   out 32   word-aligned read address
//    mem_rdata  in  32   read data, valid with mem_ack
//    mem_ack    in   1   read data returned (1..N cycles after mem_rd_en)
//    wb_valid   out  1   one-cycle pulse, wb_data valid
//    wb_data    out 32   extracted and extended load result (held)
//    adel       out  1   one-cycle misaligned-address error pulse
//
// Configuration:
//    LOAD_ALIGN_CHECK_EN  when defined, misaligned LW/LH/LHU requests raise
//                         adel instead of issuing a read. When undefined,
//                         adel is constant 0, LW ignores addr[1:0] and
//                         LH/LHU look at addr[1] only.
// ---------------------------------------------------------------------------
module load_extend (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  load_op,
   input  logic [31:0] addr,
   input  logic        flush,
   output logic        busy,
   output logic        mem_rd_en,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        adel
);

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  op_q, op_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        wb_valid_q, wb_valid_d;
   logic        adel_q, adel_d;
   logic        busy_q, busy_d;
   logic        rd_en_s;
   logic        op_ok_s;
   logic        misalign_s;

   // Select the addressed lane of the read word and extend it to 32 bits.
   function automatic logic [31:0] extend_load(input logic [2:0]  op,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      half_v = off[1] ? d[31:16] : d[15:0];
      case (off)
         2'd0:    byte_v = d[7:0];
         2'd1:    byte_v = d[15:8];
         2'd2:    byte_v = d[23:16];
         2'd3:    byte_v = d[31:24];
         default: byte_v = 8'h00;
      endcase
      case (op)
         OP_LW:   extend_load = d;
         OP_LH:   extend_load = {{16{half_v[15]}}, half_v};
         OP_LHU:  extend_load = {16'h0000, half_v};
         OP_LB:   extend_load = {{24{byte_v[7]}}, byte_v};
         OP_LBU:  extend_load = {24'h000000, byte_v};
         default: extend_load = 32'h0000_0000;
      endcase
   endfunction

   // Next-state, capture and strobe logic.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      off_d      = off_q;
      mem_addr_d = mem_addr_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = 1'b0;
      adel_d     = 1'b0;
      rd_en_s    = 1'b0;
      op_ok_s    = (load_op <= OP_LBU);
`ifdef LOAD_ALIGN_CHECK_EN
      misalign_s = ((load_op == OP_LW) && (addr[1:0] != 2'b00)) ||
                   (((load_op == OP_LH) || (load_op == OP_LHU)) && addr[0]);
`else
      misalign_s = 1'b0;
`endif
      if (reset) begin
         // The register block clears everything; only keep the strobe quiet.
         rd_en_s = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (flush) begin
                  state_d = IDLE;
               end else if (req_valid && op_ok_s) begin
                  if (misalign_s) begin
                     adel_d = 1'b1;
                  end else begin
                     rd_en_s    = 1'b1;
                     op_d       = load_op;
                     off_d      = addr[1:0];
                     mem_addr_d = {addr[31:2], 2'b00};
                     state_d    = WAIT;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT: begin
               if (flush) begin
                  state_d = IDLE;
               end else if (mem_ack) begin
                  wb_data_d  = extend_load(op_q, off_q, mem_rdata);
                  wb_valid_d = 1'b1;
                  state_d    = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
            RESP: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         op_q       <= 3'd0;
         off_q      <= 2'd0;
         mem_addr_q <= 32'h0000_0000;
         wb_data_q  <= 32'h0000_0000;
         wb_valid_q <= 1'b0;
         adel_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         off_q      <= off_d;
         mem_addr_q <= mem_addr_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         adel_q     <= adel_d;
         busy_q     <= busy_d;
      end
   end

   // The read strobe and its address must appear in the accepting cycle, so
   // they come straight from the next-state logic; mem_addr otherwise holds
   // the last issued address.
   assign mem_rd_en = rd_en_s;
   assign mem_addr  = mem_addr_d;
   assign busy      = busy_q;
   assign wb_valid  = wb_valid_q;
   assign wb_data   = wb_data_q;
   assign adel      = adel_q;

endmodule

// File: tb/tb_load_extend.sv
module tb_load_extend;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  load_op;
   logic [31:0] addr;
   logic        flush;
   logic        busy;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic        adel;

   int total = 0;
   int bad   = 0;
   logic [31:0] last_wb;

   always #5 clk = ~clk;

   load_extend dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .load_op   (load_op),
      .addr      (addr),
      .flush     (flush),
      .busy      (busy),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .wb_valid  (wb_valid),
      .wb_data   (wb_data),
      .adel      (adel)
   );

   // Reference: pick the lane by shifting, extend by arithmetic on its value.
   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] d);
      int unsigned u;
      int          sh;
      case (op)
         3'd0: return d;
         3'd1, 3'd2: begin
            sh = (a[1] == 1'b1) ? 16 : 0;
            u  = (d >> sh) % 65536;
            if (op == 3'd1 && u >= 32768) u = u + 32'hFFFF_0000;
            return u;
         end
         3'd3, 3'd4: begin
            sh = 8 * int'(a[1:0]);
            u  = (d >> sh) % 256;
            if (op == 3'd3 && u >= 128) u = u + 32'hFFFF_FF00;
            return u;
         end
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] op, input logic [31:0] a);
`ifdef LOAD_ALIGN_CHECK_EN
      return (op == 3'd0 && a[1:0] != 2'b00) || ((op == 3'd1 || op == 3'd2) && a[0]);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // One complete load; busy_cnt counts busy cycles after acceptance.
   task automatic do_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                          input int lat, output int busy_cnt);
      logic [31:0] exp;
      busy_cnt = 0;
      req_valid = 1'b1; load_op = op; addr = a;
      #1;
      if (op > 3'd4) begin
         total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL rsv_rd_en op=%0d got=%b exp=0", op, mem_rd_en); end
         tick; req_valid = 1'b0; #1;
         total++; if (busy !== 1'b0 || adel !== 1'b0) begin bad++; $display("FAIL rsv_state busy=%b adel=%b exp=0,0", busy, adel); end
         total++; if (wb_data !== last_wb) begin bad++; $display("FAIL rsv_hold got=%h exp=%h", wb_data, last_wb); end
         return;
      end
      if (ref_misaligned(op, a)) begin
         total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL adel_rd_en got=%b exp=0", mem_rd_en); end
         tick; req_valid = 1'b0; #1;
         total++; if (adel !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL adel_pulse adel=%b busy=%b exp=1,0", adel, busy); end
         tick;
         total++; if (adel !== 1'b0) begin bad++; $display("FAIL adel_clear got=%b exp=0", adel); end
         return;
      end
      exp = ref_load(op, a, d);
      total++; if (mem_rd_en !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL issue rd_en=%b busy=%b exp=1,0", mem_rd_en, busy); end
      total++; if (mem_addr !== (a & 32'hFFFF_FFFC)) begin bad++; $display("FAIL mem_addr got=%h exp=%h", mem_addr, a & 32'hFFFF_FFFC); end
      tick; req_valid = 1'b0; load_op = 3'($urandom); addr = $urandom; #1;
      for (int k = 1; k < lat; k++) begin
         if (busy === 1'b1) busy_cnt++;
         total++; if (busy !== 1'b1 || mem_rd_en !== 1'b0 || wb_valid !== 1'b0) begin
            bad++; $display("FAIL wait k=%0d busy=%b rd_en=%b wb_valid=%b exp=1,0,0", k, busy, mem_rd_en, wb_valid); end
         tick; #1;
      end
      mem_ack = 1'b1; mem_rdata = d; #1;
      if (busy === 1'b1) busy_cnt++;
      total++; if (busy !== 1'b1 || mem_rd_en !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL ack_cycle busy=%b rd_en=%b wb_valid=%b exp=1,0,0", busy, mem_rd_en, wb_valid); end
      tick; mem_ack = 1'($urandom); mem_rdata = $urandom; #1;
      if (busy === 1'b1) busy_cnt++;
      total++; if (wb_valid !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL resp wb_valid=%b busy=%b exp=1,1", wb_valid, busy); end
      total++; if (wb_data !== exp) begin bad++; $display("FAIL wb_data op=%0d addr=%h rdata=%h got=%h exp=%h", op, a, d, wb_data, exp); end
      tick; mem_ack = 1'b0; #1;
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_data !== exp) begin
         bad++; $display("FAIL after_resp wb_valid=%b busy=%b data=%h exp=0,0,%h", wb_valid, busy, wb_data, exp); end
      last_wb = exp;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b1; load_op = 3'd0; addr = 32'h0000_0044;
      flush = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
      tick; tick;
      total++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || wb_valid !== 1'b0 || adel !== 1'b0) begin
         bad++; $display("FAIL reset_ctl busy=%b rd_en=%b wb_valid=%b adel=%b exp=0", busy, mem_rd_en, wb_valid, adel); end
      total++; if (wb_data !== 32'h0 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL reset_data wb_data=%h mem_addr=%h exp=0,0", wb_data, mem_addr); end
      reset = 1'b0; req_valid = 1'b0; addr = 32'h0;
      last_wb = 32'h0;
      tick;
   endtask

   task automatic test_vectors;
      int bc;
      do_load(3'd3, 32'h0000_0013, 32'h80FF_7F01, 1, bc);
      do_load(3'd2, 32'h0000_0022, 32'h9ABC_1234, 1, bc);
      do_load(3'd1, 32'h0000_0022, 32'h9ABC_1234, 2, bc);
      do_load(3'd4, 32'h0000_0021, 32'h9ABC_1234, 3, bc);
      do_load(3'd1, 32'h0000_0003, 32'h9ABC_1234, 1, bc);
      do_load(3'd6, 32'h0000_0010, 32'h1111_1111, 1, bc);
   endtask

   task automatic test_lw_delay;
      int bc;
      do_load(3'd0, 32'h0000_0040, 32'hDEAD_BEEF, 5, bc);
      total++; if (bc !== 6) begin bad++; $display("FAIL lw_busy_cycles got=%0d exp=6", bc); end
   endtask

   task automatic test_flush;
      int bc;
      req_valid = 1'b1; load_op = 3'd0; addr = 32'h0000_0100; #1;
      tick; req_valid = 1'b0; #1;
      tick; mem_ack = 1'b1; mem_rdata = 32'h1234_5678; flush = 1'b1; #1;
      tick; mem_ack = 1'b0; flush = 1'b0; #1;
      total++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL flush_wait busy=%b wb_valid=%b exp=0,0", busy, wb_valid); end
      do_load(3'd3, 32'h0000_0201, 32'h0000_8000, 2, bc);
      // flush beats a request arriving in IDLE
      req_valid = 1'b1; load_op = 3'd0; addr = 32'h0000_0300; flush = 1'b1; #1;
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL flush_idle rd_en=%b exp=0", mem_rd_en); end
      tick; req_valid = 1'b0; flush = 1'b0; #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; load_op = 3'd3; addr = 32'h0000_0055; #1;
      tick; req_valid = 1'b0; reset = 1'b1; #1;
      tick; reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF; #1;
      total++; if (busy !== 1'b0 || wb_valid !== 1'b0 || mem_rd_en !== 1'b0 || adel !== 1'b0) begin
         bad++; $display("FAIL rst_mid_ctl busy=%b wb_valid=%b rd_en=%b adel=%b exp=0", busy, wb_valid, mem_rd_en, adel); end
      total++; if (wb_data !== 32'h0 || mem_addr !== 32'h0) begin
         bad++; $display("FAIL rst_mid_data wb_data=%h mem_addr=%h exp=0,0", wb_data, mem_addr); end
      tick; mem_ack = 1'b0; #1;
      total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL rst_mid_after wb_valid=%b busy=%b exp=0,0", wb_valid, busy); end
      last_wb = 32'h0;
   endtask

   task automatic test_ack_idle;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
      tick; tick;
      total++; if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== last_wb) begin
         bad++; $display("FAIL ack_idle busy=%b wb_valid=%b data=%h exp=0,0,%h", busy, wb_valid, wb_data, last_wb); end
      mem_ack = 1'b0;
   endtask

   task automatic test_random;
      int bc;
      for (int i = 0; i < 60; i++) begin
         do_load(3'($urandom_range(7, 0)), $urandom, $urandom, $urandom_range(4, 1), bc);
      end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_lw_delay;
      test_flush;
      test_reset_mid;
      test_ack_idle;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
